// File: rtl/be_define.sv
// Shared definitions for the data-side memory access stage.
//   - lsop size encodings (WORDop/HALFop/BYTEop; 2'b11 behaves as WORD)
//   - FSM state encoding for mem_access_unit
//   - misalignment masks and a helper that flags an illegal address/size pair
package be_define;

  localparam logic [1:0] WORDop = 2'b00;
  localparam logic [1:0] HALFop = 2'b01;
  localparam logic [1:0] BYTEop = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    FINISH = 2'b10
  } state_t;

  // Address bits that must be zero for each access size.
  localparam logic [1:0] HALF_MISALIGN = 2'b01;
  localparam logic [1:0] WORD_MISALIGN = 2'b11;

  function automatic logic misaligned(input logic [1:0] op, input logic [1:0] a);
    case (op)
      HALFop:  return |(a & HALF_MISALIGN);
      BYTEop:  return 1'b0;
      default: return |(a & WORD_MISALIGN);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide data memory bus with per-byte enables.
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata : driven by the access unit (master)
//   bus_rdata/bus_ack                         : driven by the memory (slave)
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// load_align: combinational lane select and extension for loads.
//   bus_rdata   : raw word from the bus
//   lsop        : access size (WORD/HALF/BYTE, 2'b11 = WORD)
//   addr_lo     : byte offset within the word
//   unsigned_ld : 1 = zero-extend, 0 = sign-extend sub-word loads
//   ld_data     : aligned, extended 32-bit result
module load_align
  import be_define::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [1:0]  lsop,
  input  logic [1:0]  addr_lo,
  input  logic        unsigned_ld,
  output logic [31:0] ld_data
);

  function automatic logic [31:0] ext8(input logic signed [7:0] v, input logic zx);
    return zx ? {24'h0, v} : {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] ext16(input logic signed [15:0] v, input logic zx);
    return zx ? {16'h0, v} : {{16{v[15]}}, v};
  endfunction

  logic signed [7:0]  byte_lane;
  logic signed [15:0] half_lane;

  always_comb begin
    byte_lane = bus_rdata[{addr_lo, 3'b000} +: 8];
    half_lane = bus_rdata[{addr_lo[1], 4'b0000} +: 16];
    case (lsop)
      BYTEop:  ld_data = ext8(byte_lane, unsigned_ld);
      HALFop:  ld_data = ext16(half_lane, unsigned_ld);
      default: ld_data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-side memory access stage after the multicycle controller.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mem_rd, mem_wr      : one-cycle load/store start strobes (store wins if both)
//   lsop, unsigned_ld   : access size and load zero-extension flag
//   addr, wdata         : byte address and right-justified store data
//   busy, done, err     : access in flight, completion pulse, error pulse with done
//   rdata               : MDR holding the last extended load result
//   bus                 : word bus master (request, byte enables, data, ack)
// Misaligned requests skip the bus and finish with err; an access whose ack
// does not arrive within TIMEOUT cycles of bus_req is aborted with err.
module mem_access_unit
  import be_define::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_rd,
  input  logic               mem_wr,
  input  logic [1:0]         lsop,
  input  logic               unsigned_ld,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        rdata,
  mem_access_unit_if.master  bus
);

  function automatic logic [3:0] be_for(input logic [1:0] op, input logic [1:0] a);
    case (op)
      BYTEop:  return 4'b0001 << a;
      HALFop:  return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_for(input logic [1:0] op, input logic [31:0] d);
    case (op)
      BYTEop:  return {4{d[7:0]}};
      HALFop:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept, ld_capture, timeout, cnt_inc, cnt_clr;

  logic [1:0]         lsop_p1, alo_p1;
  logic               uns_p1, we_p1, err_pend_p1;
  logic [29:0]        bus_addr_p1;
  logic [3:0]         bus_be_p1;
  logic [31:0]        bus_wdata_p1, rdata_p1, ld_ext;

  load_align u_load_align (
    .bus_rdata   (bus.bus_rdata),
    .lsop        (lsop_p1),
    .addr_lo     (alo_p1),
    .unsigned_ld (uns_p1),
    .ld_data     (ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    ld_capture = 1'b0;
    timeout    = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    busy       = (state_q != IDLE);
    done       = (state_q == FINISH);
    err        = (state_q == FINISH) & err_pend_p1;
    bus.bus_req = (state_q == ACCESS);
    bus.bus_we  = (state_q == ACCESS) & we_p1;
    case (state_q)
      IDLE: begin
        if (mem_rd || mem_wr) begin
          accept  = 1'b1;
          state_d = misaligned(lsop, addr[1:0]) ? FINISH : ACCESS;
        end
      end
      ACCESS: begin
        // An ack in the timeout cycle still completes the access.
        if (bus.bus_ack) begin
          ld_capture = ~we_p1;
          state_d    = FINISH;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      FINISH: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch (p1) and MDR capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsop_p1      <= WORDop;
      alo_p1       <= 2'b00;
      uns_p1       <= 1'b0;
      we_p1        <= 1'b0;
      err_pend_p1  <= 1'b0;
      bus_addr_p1  <= '0;
      bus_be_p1    <= 4'b0000;
      bus_wdata_p1 <= '0;
      rdata_p1     <= '0;
      cnt_q        <= '0;
    end else begin
      if (accept) begin
        lsop_p1      <= lsop;
        alo_p1       <= addr[1:0];
        uns_p1       <= unsigned_ld;
        we_p1        <= mem_wr;
        err_pend_p1  <= misaligned(lsop, addr[1:0]);
        bus_addr_p1  <= addr[31:2];
        bus_be_p1    <= be_for(lsop, addr[1:0]);
        bus_wdata_p1 <= wdata_for(lsop, wdata);
      end
      if (timeout)    err_pend_p1 <= 1'b1;
      if (ld_capture) rdata_p1    <= ld_ext;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign rdata         = rdata_p1;
  assign bus.bus_addr  = bus_addr_p1;
  assign bus.bus_be    = bus_be_p1;
  assign bus.bus_wdata = bus_wdata_p1;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit: zero-wait and wait-state accesses,
// misalignment, timeout (with and without a last-cycle ack) and reset mid-access.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_rd, mem_wr, unsigned_ld;
  logic [1:0]  lsop;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_mis = 0;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .lsop        (lsop),
    .unsigned_ld (unsigned_ld),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .bus         (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a strobe for one cycle; returns in the first cycle after acceptance.
  task automatic start(input logic rd, input logic wr, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] d, input logic uns);
    mem_rd = rd; mem_wr = wr; lsop = op; addr = a; wdata = d; unsigned_ld = uns;
    tick;
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; lsop = 2'b00; unsigned_ld = 1'b0;
    addr = '0; wdata = '0; bus_if.bus_rdata = '0; bus_if.bus_ack = 1'b0;

    // Reset state
    #2;
    chk1 ("rst_busy",   busy, 1'b0);
    chk1 ("rst_done",   done, 1'b0);
    chk1 ("rst_err",    err, 1'b0);
    chk1 ("rst_req",    bus_if.bus_req, 1'b0);
    chk1 ("rst_we",     bus_if.bus_we, 1'b0);
    chk32("rst_be",     32'(bus_if.bus_be), 32'h0);
    chk32("rst_addr",   32'(bus_if.bus_addr), 32'h0);
    chk32("rst_wdata",  bus_if.bus_wdata, 32'h0);
    chk32("rst_rdata",  rdata, 32'h0);
    #10 rst_n = 1'b1;
    tick;

    // Zero-wait signed byte load, lane 3
    start(1'b1, 1'b0, 2'b10, 32'h0000_1003, 32'h0, 1'b0);
    chk1 ("t1_req",  bus_if.bus_req, 1'b1);
    chk1 ("t1_busy", busy, 1'b1);
    chk1 ("t1_we",   bus_if.bus_we, 1'b0);
    chk32("t1_be",   32'(bus_if.bus_be), 32'h8);
    chk32("t1_addr", 32'(bus_if.bus_addr), 32'h400);
    chk1 ("t1_done_early", done, 1'b0);
    bus_if.bus_rdata = 32'h8012_3456; bus_if.bus_ack = 1'b1;
    tick;
    bus_if.bus_ack = 1'b0;
    chk1 ("t1_done",  done, 1'b1);
    chk1 ("t1_err",   err, 1'b0);
    chk1 ("t1_req_off", bus_if.bus_req, 1'b0);
    chk1 ("t1_busy_fin", busy, 1'b1);
    chk32("t1_rdata", rdata, 32'hFFFF_FF80);
    tick;
    chk1 ("t1_busy_idle", busy, 1'b0);
    chk1 ("t1_done_off",  done, 1'b0);

    // Unsigned upper halfword load
    start(1'b1, 1'b0, 2'b01, 32'h0000_2002, 32'h0, 1'b1);
    chk32("t2_be", 32'(bus_if.bus_be), 32'hC);
    bus_if.bus_rdata = 32'h9ABC_1234; bus_if.bus_ack = 1'b1;
    tick;
    bus_if.bus_ack = 1'b0;
    chk1 ("t2_done",  done, 1'b1);
    chk32("t2_rdata", rdata, 32'h0000_9ABC);
    tick;

    // Byte store with 3 wait states; ack in the 4th request cycle
    bus_if.bus_rdata = 32'hDEAD_BEEF;
    start(1'b0, 1'b1, 2'b10, 32'h0000_0001, 32'h0000_00A5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk1 ("t3_req",   bus_if.bus_req, 1'b1);
      chk1 ("t3_we",    bus_if.bus_we, 1'b1);
      chk32("t3_be",    32'(bus_if.bus_be), 32'h2);
      chk32("t3_wdata", bus_if.bus_wdata, 32'hA5A5_A5A5);
      chk1 ("t3_done_early", done, 1'b0);
      if (i == 3) bus_if.bus_ack = 1'b1;
      tick;
    end
    bus_if.bus_ack = 1'b0;
    chk1 ("t3_done",  done, 1'b1);
    chk1 ("t3_err",   err, 1'b0);
    chk32("t3_rdata", rdata, 32'h0000_9ABC);
    tick;

    // Halfword store replication, and store wins over a simultaneous load
    start(1'b1, 1'b1, 2'b01, 32'h0000_0000, 32'hFFFF_BEEF, 1'b0);
    chk1 ("t4_we",    bus_if.bus_we, 1'b1);
    chk32("t4_be",    32'(bus_if.bus_be), 32'h3);
    chk32("t4_wdata", bus_if.bus_wdata, 32'hBEEF_BEEF);
    bus_if.bus_ack = 1'b1;
    tick;
    bus_if.bus_ack = 1'b0;
    chk1 ("t4_done",  done, 1'b1);
    chk32("t4_rdata", rdata, 32'h0000_9ABC);
    tick;

    // Misaligned word: no bus cycle, immediate error completion
    start(1'b1, 1'b0, 2'b00, 32'h0000_0006, 32'h0, 1'b0);
    chk1 ("t5_req",  bus_if.bus_req, 1'b0);
    chk1 ("t5_done", done, 1'b1);
    chk1 ("t5_err",  err, 1'b1);
    chk1 ("t5_busy", busy, 1'b1);
    tick;
    chk1 ("t5_busy_idle", busy, 1'b0);
    chk1 ("t5_err_off",   err, 1'b0);

    // Timeout: 16 request cycles without ack
    bus_if.bus_rdata = 32'hCAFE_F00D;
    start(1'b1, 1'b0, 2'b00, 32'h0000_0010, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk1("t6_req", bus_if.bus_req, 1'b1);
      chk1("t6_done_early", done, 1'b0);
      tick;
    end
    chk1 ("t6_req_off", bus_if.bus_req, 1'b0);
    chk1 ("t6_done",  done, 1'b1);
    chk1 ("t6_err",   err, 1'b1);
    chk32("t6_rdata", rdata, 32'h0000_9ABC);
    tick;

    // Ack in the 16th request cycle wins over the timeout
    start(1'b1, 1'b0, 2'b00, 32'h0000_0010, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk1("t7_req", bus_if.bus_req, 1'b1);
      if (i == 15) begin
        bus_if.bus_rdata = 32'h1122_3344;
        bus_if.bus_ack   = 1'b1;
      end
      tick;
    end
    bus_if.bus_ack = 1'b0;
    chk1 ("t7_done",  done, 1'b1);
    chk1 ("t7_err",   err, 1'b0);
    chk32("t7_rdata", rdata, 32'h1122_3344);
    tick;

    // Reset asserted mid-access, then a clean word load
    start(1'b1, 1'b0, 2'b00, 32'h0000_0020, 32'h0, 1'b0);
    chk1("t8_req", bus_if.bus_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1 ("t8_req_rst",  bus_if.bus_req, 1'b0);
    chk1 ("t8_busy_rst", busy, 1'b0);
    chk1 ("t8_done_rst", done, 1'b0);
    chk32("t8_rdata_rst", rdata, 32'h0);
    #3 rst_n = 1'b1;
    tick;
    chk1("t8_idle_done", done, 1'b0);
    start(1'b1, 1'b0, 2'b00, 32'h0000_0000, 32'h0, 1'b0);
    chk32("t8_addr", 32'(bus_if.bus_addr), 32'h0);
    chk32("t8_be",   32'(bus_if.bus_be), 32'hF);
    bus_if.bus_rdata = 32'h1234_5678; bus_if.bus_ack = 1'b1;
    tick;
    bus_if.bus_ack = 1'b0;
    chk1 ("t8_done",  done, 1'b1);
    chk1 ("t8_err",   err, 1'b0);
    chk32("t8_rdata", rdata, 32'h1234_5678);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
